// File: rtl/freq_div_sequencer.sv
// Sequences divider ratio changes: waits for a divider falling edge, applies the
// new select code, holds it for a settle period and acknowledges. Optional auto-sweep.
module freq_div_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int DWELL_CYCLES  = 256,
    parameter int EDGE_TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    input  logic       sweep_en,
    input  logic       div_out,
    output logic [1:0] select,
    output logic       busy,
    output logic       done,
    output logic       timeout
);
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DWELL_W  = (DWELL_CYCLES  > 1) ? $clog2(DWELL_CYCLES)  : 1;
    localparam int WAIT_W   = (EDGE_TIMEOUT  > 1) ? $clog2(EDGE_TIMEOUT)  : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_EDGE = 3'd1;
    localparam logic [2:0] APPLY     = 3'd2;
    localparam logic [2:0] SETTLE    = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;

    logic [2:0]          r_state;
    logic [1:0]          r_select;
    logic [1:0]          r_pending_sel;
    logic                r_div_q;
    logic                r_timeout;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [DWELL_W-1:0]  r_dwell_cnt;

    logic       w_fall;
    logic       w_wait_expired;
    logic       w_settle_last;
    logic       w_sweep_req;
    logic       w_accept;
    logic [1:0] w_next_sel;

    assign w_fall         = r_div_q & ~div_out;
    assign w_wait_expired = (r_wait_cnt == WAIT_W'(EDGE_TIMEOUT - 1));
    assign w_settle_last  = (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
    assign w_sweep_req    = sweep_en && (r_state == IDLE) &&
                            (r_dwell_cnt == DWELL_W'(DWELL_CYCLES - 1));
    assign w_accept       = (r_state == IDLE) && (req_valid || w_sweep_req);
    // An external request always beats a simultaneous sweep step.
    assign w_next_sel     = req_valid ? req_sel : r_select + 2'd1;

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == ACK);
    assign select    = r_select;
    assign timeout   = r_timeout;

    // NOTE: sequential state uses non-blocking assignments only; a later
    // assignment to the same register in this block overrides an earlier one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_select      <= 2'b00;
            r_pending_sel <= 2'b00;
            r_div_q       <= 1'b0;
            r_timeout     <= 1'b0;
            r_wait_cnt    <= '0;
            r_settle_cnt  <= '0;
            r_dwell_cnt   <= '0;
        end else begin
            r_div_q     <= div_out;
            r_dwell_cnt <= '0;
            case (r_state)
                IDLE: begin
                    r_wait_cnt   <= '0;
                    r_settle_cnt <= '0;
                    if (w_accept) begin
                        r_pending_sel <= w_next_sel;
                        r_state       <= (w_next_sel == r_select) ? ACK : WAIT_EDGE;
                    end else if (sweep_en) begin
                        r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
                    end
                end
                WAIT_EDGE: begin
                    // Select is loaded on entry so the new code is visible during APPLY.
                    if (w_fall || w_wait_expired) begin
                        r_select <= r_pending_sel;
                        r_state  <= APPLY;
                        if (!w_fall) r_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                APPLY: r_state <= SETTLE;
                SETTLE: begin
                    if (w_settle_last) r_state <= ACK;
                    else               r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/freq_div_sequencer.md
FREQ_DIV_SEQUENCER -- requirements
Module: freq_div_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: clk cycles `select` is held stable after a change before acknowledgement.
REQ-002 SHALL have parameter DWELL_CYCLES, default 256: clk cycles spent on each ratio in sweep mode.
REQ-003 SHALL have parameter EDGE_TIMEOUT, default 64: maximum clk cycles to wait for a divider falling edge.
REQ-004 SHALL have one clock; reset is asynchronous and active-high; ports `clk` and `rst`.
REQ-005 Ports: clk  in  1  system clock, same clock that drives the frequency divider.
REQ-006 Ports: rst  in  1  asynchronous active-high reset.
REQ-007 Ports: req_valid  in  1  ratio-change request.
REQ-008 Ports: req_sel  in  2  requested divider select code.
REQ-009 Ports: req_ready  out  1  high when a request is accepted this cycle.
REQ-010 Ports: sweep_en  in  1  auto-sweep enable.
REQ-011 Ports: div_out  in  1  divider output clock, sampled as data on clk.
REQ-012 Ports: select  out  2  registered select code driven to the divider.
REQ-013 Ports: busy  out  1  high in any state other than IDLE.
REQ-014 Ports: done  out  1  one-cycle pulse when a change completes.
REQ-015 Ports: timeout  out  1  sticky flag: a change was applied without a divider edge.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_EDGE, APPLY, SETTLE, ACK.
REQ-017 req_ready SHALL be high only in IDLE; a request is accepted on req_valid & req_ready, and req_sel is latched into pending_sel.
REQ-018 On acceptance the FSM SHALL go to WAIT_EDGE, except when pending_sel == select, in which case it SHALL go directly to ACK (done pulse, no select change).
REQ-019 A falling edge SHALL be detected when div_out_q == 1 and div_out == 0, where div_out_q is div_out registered once.
REQ-020 WAIT_EDGE -> APPLY SHALL occur on the first falling edge, or when the wait counter reaches EDGE_TIMEOUT-1; the timeout path sets timeout = 1.
REQ-021 APPLY SHALL last one cycle and load select <= pending_sel; select SHALL change at no other time.
REQ-022 SETTLE SHALL count exactly SETTLE_CYCLES cycles, then go to ACK.
REQ-023 ACK SHALL last one cycle with done = 1, then go to IDLE.
REQ-024 Latency with an edge present SHALL be accept -> select change: edge wait + 1 cycle; select change -> done: SETTLE_CYCLES + 1 cycles.
REQ-025 Sweep: while sweep_en = 1 and the FSM is in IDLE, a dwell counter SHALL count; at DWELL_CYCLES-1 it SHALL issue an internal request with pending_sel = select + 1 (modulo 4, 11 wraps to 00) and clear itself.
REQ-026 An external req_valid in the same cycle as an internal sweep request SHALL win; the dwell counter SHALL clear.
REQ-027 Deasserting sweep_en SHALL clear the dwell counter; a change already in progress SHALL complete.
REQ-028 req_valid outside IDLE SHALL be ignored; the requester holds it until req_ready.
REQ-029 All counters SHALL be wide enough for their parameter and SHALL not wrap within a state.
REQ-030 timeout SHALL clear only on reset.

Reset
REQ-031 On rst = 1, immediately and asynchronously: state = IDLE, select = 2'b00, pending_sel = 0, all counters = 0, div_out_q = 0, done = 0, timeout = 0, busy = 0; req_ready SHALL be 1 after release.
REQ-032 rst asserted mid-change (any state) SHALL abort the change; select returns to 00 and no done pulse is produced.

Verification
REQ-033 Reset, then req_sel = 2 with div_out toggling every 4 clk -> select = 2 one cycle after the first falling edge, done exactly SETTLE_CYCLES + 1 cycles later, timeout = 0.
REQ-034 req_sel = 0 while select = 0 -> done two cycles after acceptance, select unchanged, busy high for one cycle.
REQ-035 div_out held at 0, req_sel = 3 -> select = 3 at EDGE_TIMEOUT + 1 cycles after acceptance, timeout = 1 and it stays set.
REQ-036 sweep_en = 1 from select = 3 -> next select = 0 after the dwell period plus edge wait; consecutive done pulses spaced by DWELL_CYCLES + the change latency.
REQ-037 rst pulsed during SETTLE -> select = 0 and state = IDLE immediately; no done pulse; a new request is accepted after release.
REQ-038 External request in the same cycle as sweep expiry with req_sel = 1 -> pending_sel = 1 and the dwell counter = 0.
